// File: rtl/audio_stream_pkg.sv
// audio_stream_pkg
//   Shared constants for the audio sample FIFO: register word indices
//   (wb_adr_i[4:2]), CTRL/STAT bit positions, default sample width and
//   the unity gain value used by the optional volume stage.
package audio_stream_pkg;

  localparam int SAMPLE_W_DEF = 24;

  // Word index of each register (byte offset >> 2)
  localparam logic [2:0] REG_CTRL  = 3'd0;  // 0x00
  localparam logic [2:0] REG_STAT  = 3'd1;  // 0x04
  localparam logic [2:0] REG_LEFT  = 3'd2;  // 0x08
  localparam logic [2:0] REG_RIGHT = 3'd3;  // 0x0C
  localparam logic [2:0] REG_UNDR  = 3'd4;  // 0x10
  localparam logic [2:0] REG_VOL   = 3'd5;  // 0x14

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_FLUSH_BIT = 1;
  localparam int CTRL_THR_LSB   = 8;
  localparam int CTRL_THR_MSB   = 15;

  localparam int STAT_EMPTY_BIT = 16;
  localparam int STAT_FULL_BIT  = 17;
  localparam int STAT_IRQ_BIT   = 18;
  localparam int STAT_OVF_BIT   = 19;

  typedef logic [8:0] gain_t;
  localparam gain_t GAIN_UNITY = 9'd256;

endpackage

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram
//   Single-clock FIFO storage with wrapping read/write pointers and an
//   explicit level counter. Read data is the current head (combinational).
// Ports
//   clk, rstn        clock, async active-low reset
//   flush            clears pointers and level; overrides push and pop
//   push, wdata      write one entry (ignored when full)
//   pop              advance the head (ignored when empty)
//   rdata            head entry
//   level            entries held, DEPTH_LOG2+1 bits
//   full, empty      status flags
module sync_fifo_ram #(
  parameter int WIDTH      = 48,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  flush,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (level == {1'b1, {DEPTH_LOG2{1'b0}}});
  assign empty   = (level == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/audio_stream_fifo.sv
// audio_stream_fifo
//   Wishbone-slave stereo sample buffer feeding i2s_master. The CPU stages a
//   left sample, then writing the right sample pushes the pair. Pairs are
//   popped to frame_l_o/frame_r_o with a one-cycle frame_valid_o strobe
//   whenever enabled, non-empty and the sink is not full.
//   Build option AUDIO_FIFO_VOLUME_EN adds a VOLUME register (0x14) and a
//   saturating gain stage, which adds one cycle of output latency.
// Ports
//   clk, rstn                     SoC clock, async active-low reset
//   wb_adr_i/dat_i/sel_i/we_i/stb_i  Wishbone request (only adr[4:2] decoded)
//   wb_dat_o, wb_ack_o, wb_stall_o   Wishbone response (ack 1 cycle after stb)
//   frame_l_o, frame_r_o, frame_valid_o  sample pair to i2s_master
//   sink_full_i                   i2s_master cannot accept a frame
//   irq_o                         level IRQ: enable && level <= threshold
module audio_stream_fifo
  import audio_stream_pkg::*;
#(
  parameter int          SAMPLE_W   = SAMPLE_W_DEF,
  parameter int          DEPTH_LOG2 = 6,
  parameter logic [31:0] BASE_ADDR  = 32'hF000_0100
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [31:0]         wb_adr_i,
  input  logic [31:0]         wb_dat_i,
  input  logic [3:0]          wb_sel_i,
  input  logic                wb_we_i,
  input  logic                wb_stb_i,
  output logic [31:0]         wb_dat_o,
  output logic                wb_ack_o,
  output logic                wb_stall_o,
  output logic [SAMPLE_W-1:0] frame_l_o,
  output logic [SAMPLE_W-1:0] frame_r_o,
  output logic                frame_valid_o,
  input  logic                sink_full_i,
  output logic                irq_o
);

  localparam int PAIR_W = 2 * SAMPLE_W;

  logic [2:0]            reg_idx;
  logic                  bus_wr;
  logic                  bus_rd;
  logic                  ctrl_en;
  logic [7:0]            irq_thr;
  logic [SAMPLE_W-1:0]   left_stage;
  logic [15:0]           undr_cnt;
  logic                  ovf_sticky;
  logic                  starved;
  logic                  starved_q;
  logic                  flush;
  logic                  push_req;
  logic                  pop;
  logic [PAIR_W-1:0]     head;
  logic [DEPTH_LOG2:0]   level;
  logic                  full;
  logic                  empty;
  logic [31:0]           stat_word;
  logic [31:0]           rd_mux;
  logic                  unused_bits;

  assign reg_idx    = wb_adr_i[4:2];
  assign bus_wr     = wb_stb_i && wb_we_i;
  assign bus_rd     = wb_stb_i && !wb_we_i;
  assign wb_stall_o = 1'b0;

  // Flush is a write-side pulse only; the bit is never stored
  assign flush    = bus_wr && (reg_idx == REG_CTRL) && wb_dat_i[CTRL_FLUSH_BIT];
  assign push_req = bus_wr && (reg_idx == REG_RIGHT);
  assign pop      = ctrl_en && !empty && !sink_full_i && !flush;
  assign starved  = ctrl_en && empty && !sink_full_i;
  assign irq_o    = ctrl_en && (32'(level) <= 32'(irq_thr));

  sync_fifo_ram #(
    .WIDTH      (PAIR_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .flush (flush),
    .push  (push_req),
    .pop   (pop),
    .wdata ({left_stage, wb_dat_i[SAMPLE_W-1:0]}),
    .rdata (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

`ifdef AUDIO_FIFO_VOLUME_EN
  gain_t gain;

  function automatic logic signed [SAMPLE_W-1:0] sat_sample(
    input logic signed [SAMPLE_W+1:0] v
  );
    // Top three bits agree -> value already fits in SAMPLE_W
    if ((v[SAMPLE_W+1:SAMPLE_W-1] == 3'b000) || (v[SAMPLE_W+1:SAMPLE_W-1] == 3'b111))
      return v[SAMPLE_W-1:0];
    else if (v[SAMPLE_W+1])
      return {1'b1, {(SAMPLE_W-1){1'b0}}};
    else
      return {1'b0, {(SAMPLE_W-1){1'b1}}};
  endfunction

  function automatic logic signed [SAMPLE_W-1:0] apply_gain(
    input logic signed [SAMPLE_W-1:0] s,
    input gain_t                      g
  );
    logic signed [SAMPLE_W+9:0] prod;
    logic signed [SAMPLE_W+1:0] scaled;
    prod   = s * $signed({1'b0, g});
    scaled = prod[SAMPLE_W+9:8];  // arithmetic >>> 8
    return sat_sample(scaled);
  endfunction

  logic signed [SAMPLE_W-1:0] l_p1;
  logic signed [SAMPLE_W-1:0] r_p1;
  logic                       vld_p1;

  // Stage p1: capture popped head
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_p1 <= 1'b0;
      l_p1   <= '0;
      r_p1   <= '0;
    end else begin
      vld_p1 <= pop;
      if (pop) begin
        l_p1 <= head[PAIR_W-1:SAMPLE_W];
        r_p1 <= head[SAMPLE_W-1:0];
      end
    end
  end

  // Stage p2: gain, saturate, present to sink
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_valid_o <= 1'b0;
      frame_l_o     <= '0;
      frame_r_o     <= '0;
    end else begin
      frame_valid_o <= vld_p1;
      if (vld_p1) begin
        frame_l_o <= apply_gain(l_p1, gain);
        frame_r_o <= apply_gain(r_p1, gain);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      gain <= GAIN_UNITY;
    else if (bus_wr && (reg_idx == REG_VOL))
      gain <= wb_dat_i[8:0];
  end

  assign unused_bits = ^{wb_sel_i, wb_dat_i, wb_adr_i[31:5], wb_adr_i[1:0], BASE_ADDR[0]};
`else
  // Stage p1: popped head straight to sink
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_valid_o <= 1'b0;
      frame_l_o     <= '0;
      frame_r_o     <= '0;
    end else begin
      frame_valid_o <= pop;
      if (pop) begin
        frame_l_o <= head[PAIR_W-1:SAMPLE_W];
        frame_r_o <= head[SAMPLE_W-1:0];
      end
    end
  end

  assign unused_bits = ^{wb_sel_i, wb_dat_i, wb_adr_i[31:5], wb_adr_i[1:0], BASE_ADDR[0],
                         GAIN_UNITY};
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ctrl_en    <= 1'b0;
      irq_thr    <= '0;
      left_stage <= '0;
      undr_cnt   <= '0;
      ovf_sticky <= 1'b0;
      starved_q  <= 1'b0;
    end else begin
      starved_q <= starved;
      if (bus_wr && (reg_idx == REG_CTRL)) begin
        ctrl_en <= wb_dat_i[CTRL_EN_BIT];
        irq_thr <= wb_dat_i[CTRL_THR_MSB:CTRL_THR_LSB];
      end
      if (flush)
        left_stage <= '0;
      else if (bus_wr && (reg_idx == REG_LEFT))
        left_stage <= wb_dat_i[SAMPLE_W-1:0];
      if (bus_wr && (reg_idx == REG_UNDR)) begin
        undr_cnt   <= '0;
        ovf_sticky <= 1'b0;
      end else begin
        // Count entries into starvation, not starved cycles
        if (starved && !starved_q && (undr_cnt != 16'hFFFF))
          undr_cnt <= undr_cnt + 16'd1;
        if (push_req && full)
          ovf_sticky <= 1'b1;
      end
    end
  end

  always_comb begin
    stat_word                 = '0;
    stat_word[DEPTH_LOG2:0]   = level;
    stat_word[STAT_EMPTY_BIT] = empty;
    stat_word[STAT_FULL_BIT]  = full;
    stat_word[STAT_IRQ_BIT]   = irq_o;
    stat_word[STAT_OVF_BIT]   = ovf_sticky;
  end

  always_comb begin
    rd_mux = '0;
    case (reg_idx)
      REG_CTRL: begin
        rd_mux[CTRL_EN_BIT]               = ctrl_en;
        rd_mux[CTRL_THR_MSB:CTRL_THR_LSB] = irq_thr;
      end
      REG_STAT: rd_mux = stat_word;
      REG_UNDR: rd_mux[15:0] = undr_cnt;
`ifdef AUDIO_FIFO_VOLUME_EN
      REG_VOL:  rd_mux[8:0] = gain;
`endif
      default:  rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= wb_stb_i;
      wb_dat_o <= bus_rd ? rd_mux : '0;
    end
  end

endmodule

// File: tb/tb_audio_stream_fifo.sv
module tb_audio_stream_fifo;

  localparam logic [31:0] BASE   = 32'hF000_0100;
  localparam logic [31:0] A_CTRL = BASE + 32'h00;
  localparam logic [31:0] A_STAT = BASE + 32'h04;
  localparam logic [31:0] A_LEFT = BASE + 32'h08;
  localparam logic [31:0] A_RGHT = BASE + 32'h0C;
  localparam logic [31:0] A_UNDR = BASE + 32'h10;
  localparam logic [31:0] A_VOL  = BASE + 32'h14;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [31:0] wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [3:0]  wb_sel_i = 4'hF;
  logic        wb_we_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_stall_o;
  logic [23:0] frame_l_o;
  logic [23:0] frame_r_o;
  logic        frame_valid_o;
  logic        sink_full_i = 1'b0;
  logic        irq_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] rd;
  logic [47:0] got_q[$];

  audio_stream_fifo dut (
    .clk           (clk),
    .rstn          (rstn),
    .wb_adr_i      (wb_adr_i),
    .wb_dat_i      (wb_dat_i),
    .wb_sel_i      (wb_sel_i),
    .wb_we_i       (wb_we_i),
    .wb_stb_i      (wb_stb_i),
    .wb_dat_o      (wb_dat_o),
    .wb_ack_o      (wb_ack_o),
    .wb_stall_o    (wb_stall_o),
    .frame_l_o     (frame_l_o),
    .frame_r_o     (frame_r_o),
    .frame_valid_o (frame_valid_o),
    .sink_full_i   (sink_full_i),
    .irq_o         (irq_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rstn && frame_valid_o) got_q.push_back({frame_l_o, frame_r_o});
  end

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    wb_adr_i = addr; wb_dat_i = data; wb_we_i = 1'b1; wb_stb_i = 1'b1;
    @(negedge clk);
    wb_we_i = 1'b0; wb_stb_i = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    @(negedge clk);
    wb_adr_i = addr; wb_we_i = 1'b0; wb_stb_i = 1'b1;
    @(negedge clk);
    data = wb_dat_o;
    wb_stb_i = 1'b0;
  endtask

  task automatic test_reset();
    #2 rstn = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({frame_valid_o, irq_o, wb_ack_o, wb_stall_o} !== 4'b0) begin
      errors++; $display("FAIL reset_ctl: got %b expected 0000", {frame_valid_o, irq_o, wb_ack_o, wb_stall_o});
    end
    checks++;
    if ({frame_l_o, frame_r_o, wb_dat_o} !== 80'h0) begin
      errors++; $display("FAIL reset_data: got %h/%h/%h expected 0", frame_l_o, frame_r_o, wb_dat_o);
    end
    rstn = 1'b1;
    @(negedge clk);
    wb_adr_i = A_STAT; wb_we_i = 1'b0; wb_stb_i = 1'b1;
    @(negedge clk);
    checks++;
    if (wb_ack_o !== 1'b1 || wb_dat_o !== 32'h0001_0000) begin
      errors++; $display("FAIL reset_stat: got ack=%b data=%h expected ack=1 data=00010000", wb_ack_o, wb_dat_o);
    end
    wb_stb_i = 1'b0;
    @(negedge clk);
    checks++;
    if (wb_ack_o !== 1'b0) begin
      errors++; $display("FAIL ack_single: got %b expected 0", wb_ack_o);
    end
    bus_read(A_CTRL, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h expected 0", rd); end
    bus_read(A_UNDR, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL reset_undr: got %h expected 0", rd); end
    bus_read(A_VOL, rd);
    checks++;
`ifdef AUDIO_FIFO_VOLUME_EN
    if (rd !== 32'd256) begin errors++; $display("FAIL reset_vol: got %h expected 00000100", rd); end
`else
    if (rd !== 32'h0) begin errors++; $display("FAIL reset_vol: got %h expected 0", rd); end
`endif
  endtask

  task automatic test_single_pair();
    sink_full_i = 1'b0;
    bus_write(A_CTRL, 32'h1);
    got_q.delete();
    bus_write(A_LEFT, 32'h0012_3456);
    bus_write(A_RGHT, 32'h00AB_CDEF);
    repeat (4) @(negedge clk);
    checks++;
    if (got_q.size() != 1) begin
      errors++; $display("FAIL single_count: got %0d pulses expected 1", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== {24'h123456, 24'hABCDEF}) begin
        errors++; $display("FAIL single_data: got %h expected 123456abcdef", got_q[0]);
      end
    end
    bus_read(A_LEFT, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL left_wo_read: got %h expected 0", rd); end
    bus_read(A_STAT, rd);
    checks++;
    if (rd !== 32'h0005_0000) begin errors++; $display("FAIL single_stat: got %h expected 00050000", rd); end
  endtask

  task automatic test_overflow();
    bus_write(A_CTRL, 32'h0);
    got_q.delete();
    for (int i = 0; i < 65; i++) begin
      bus_write(A_LEFT, 32'h0010_0000 + i);
      bus_write(A_RGHT, 32'h0020_0000 + i);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (got_q.size() != 0) begin
      errors++; $display("FAIL disabled_pop: got %0d pulses expected 0", got_q.size());
    end
    bus_read(A_STAT, rd);
    checks++;
    if (rd !== 32'h000A_0040) begin errors++; $display("FAIL full_stat: got %h expected 000a0040", rd); end
    bus_write(A_CTRL, 32'h1);
    repeat (70) @(negedge clk);
    checks++;
    if (got_q.size() != 64) begin
      errors++; $display("FAIL drain_count: got %0d pulses expected 64", got_q.size());
    end else begin
      for (int i = 0; i < 64; i++) begin
        checks++;
        if (got_q[i] !== {24'(24'h100000 + i), 24'(24'h200000 + i)}) begin
          errors++; $display("FAIL drain_order[%0d]: got %h expected %h", i, got_q[i],
                             {24'(24'h100000 + i), 24'(24'h200000 + i)});
        end
      end
    end
    bus_read(A_STAT, rd);
    checks++;
    if (rd !== 32'h000D_0000) begin errors++; $display("FAIL drained_stat: got %h expected 000d0000", rd); end
  endtask

  task automatic test_underrun();
    sink_full_i = 1'b1;
    repeat (2) @(negedge clk);
    bus_write(A_UNDR, 32'h0);
    bus_read(A_UNDR, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL undr_clear: got %h expected 0", rd); end
    bus_read(A_STAT, rd);
    checks++;
    if (rd !== 32'h0005_0000) begin errors++; $display("FAIL ovf_clear: got %h expected 00050000", rd); end
    for (int k = 0; k < 3; k++) begin
      sink_full_i = 1'b0;
      repeat (3) @(negedge clk);
      sink_full_i = 1'b1;
      repeat (2) @(negedge clk);
    end
    bus_read(A_UNDR, rd);
    checks++;
    if (rd !== 32'd3) begin errors++; $display("FAIL undr_count: got %h expected 3", rd); end
    bus_write(A_UNDR, 32'hFFFF_FFFF);
    bus_read(A_UNDR, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL undr_clear2: got %h expected 0", rd); end
  endtask

  task automatic test_irq_flush();
    sink_full_i = 1'b1;
    bus_write(A_CTRL, 32'h0000_0401);
    got_q.delete();
    for (int i = 0; i < 6; i++) begin
      bus_write(A_LEFT, 32'h10 + i);
      bus_write(A_RGHT, 32'h20 + i);
    end
    @(negedge clk);
    checks++;
    if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_above: got %b expected 0", irq_o); end
    bus_read(A_STAT, rd);
    checks++;
    if (rd !== 32'h0000_0006) begin errors++; $display("FAIL stat_l6: got %h expected 00000006", rd); end
    sink_full_i = 1'b0;
    repeat (2) @(negedge clk);
    sink_full_i = 1'b1;
    checks++;
    if (irq_o !== 1'b1) begin errors++; $display("FAIL irq_at_thr: got %b expected 1", irq_o); end
    bus_read(A_STAT, rd);
    checks++;
    if (rd !== 32'h0004_0004) begin errors++; $display("FAIL stat_l4: got %h expected 00040004", rd); end
    checks++;
    if (got_q.size() != 2 || got_q[0] !== {24'h10, 24'h20}) begin
      errors++; $display("FAIL partial_drain: got %0d pulses expected 2 (head 000010000020)", got_q.size());
    end
    bus_write(A_CTRL, 32'h0000_0403);
    bus_read(A_STAT, rd);
    checks++;
    if (rd !== 32'h0005_0000) begin errors++; $display("FAIL flush_stat: got %h expected 00050000", rd); end
    checks++;
    if (irq_o !== 1'b1) begin errors++; $display("FAIL irq_after_flush: got %b expected 1", irq_o); end
    bus_read(A_CTRL, rd);
    checks++;
    if (rd !== 32'h0000_0401) begin errors++; $display("FAIL ctrl_readback: got %h expected 00000401", rd); end
    bus_write(A_LEFT, 32'h0077_7777);
    bus_write(A_CTRL, 32'h0000_0403);
    got_q.delete();
    sink_full_i = 1'b0;
    bus_write(A_RGHT, 32'h0000_0001);
    repeat (4) @(negedge clk);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== {24'h0, 24'h1}) begin
      errors++; $display("FAIL flush_left: got %0d pulses expected 1 with 000000000001", got_q.size());
    end
  endtask

  task automatic test_async_reset();
    sink_full_i = 1'b0;
    bus_write(A_CTRL, 32'h1);
    bus_write(A_LEFT, 32'h5);
    bus_write(A_RGHT, 32'h6);
    wb_adr_i = A_STAT; wb_we_i = 1'b0; wb_stb_i = 1'b1;
    @(posedge clk);
`ifdef AUDIO_FIFO_VOLUME_EN
    @(posedge clk);
`endif
    #1;
    checks++;
    if (wb_ack_o !== 1'b1 || frame_valid_o !== 1'b1) begin
      errors++; $display("FAIL pre_reset: got ack=%b valid=%b expected 1/1", wb_ack_o, frame_valid_o);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if (wb_ack_o !== 1'b0 || frame_valid_o !== 1'b0 || frame_l_o !== 24'h0) begin
      errors++; $display("FAIL async_drop: got ack=%b valid=%b l=%h expected 0/0/0", wb_ack_o, frame_valid_o, frame_l_o);
    end
    wb_stb_i = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    bus_read(A_STAT, rd);
    checks++;
    if (rd !== 32'h0001_0000) begin errors++; $display("FAIL post_reset_stat: got %h expected 00010000", rd); end
  endtask

  task automatic test_volume();
    sink_full_i = 1'b0;
    bus_write(A_CTRL, 32'h1);
`ifdef AUDIO_FIFO_VOLUME_EN
    bus_write(A_VOL, 32'd128);
    got_q.delete();
    bus_write(A_LEFT, 32'h007F_FFFE);
    bus_write(A_RGHT, 32'h0060_0000);
    repeat (4) @(negedge clk);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== {24'h3FFFFF, 24'h300000}) begin
      errors++; $display("FAIL vol_half: got %0d pulses expected 1 with 3fffff300000", got_q.size());
    end
    bus_write(A_VOL, 32'd511);
    got_q.delete();
    bus_write(A_LEFT, 32'h0040_0000);
    bus_write(A_RGHT, 32'h00A0_0000);
    repeat (4) @(negedge clk);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== {24'h7FC000, 24'h800000}) begin
      errors++; $display("FAIL vol_neg_sat: got %0d pulses expected 1 with 7fc000800000", got_q.size());
    end
    got_q.delete();
    bus_write(A_LEFT, 32'h0060_0000);
    bus_write(A_RGHT, 32'h0000_0100);
    @(posedge clk); #1;
    checks++;
    if (frame_valid_o !== 1'b0) begin errors++; $display("FAIL vol_lat1: got %b expected 0", frame_valid_o); end
    @(posedge clk); #1;
    checks++;
    if (frame_valid_o !== 1'b1 || frame_l_o !== 24'h7FFFFF || frame_r_o !== 24'h0001FF) begin
      errors++; $display("FAIL vol_lat2: got valid=%b l=%h r=%h expected 1/7fffff/0001ff", frame_valid_o, frame_l_o, frame_r_o);
    end
`else
    bus_write(A_VOL, 32'h0000_01FF);
    bus_read(A_VOL, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL vol_absent: got %h expected 0", rd); end
    got_q.delete();
    bus_write(A_LEFT, 32'h007F_FFFE);
    bus_write(A_RGHT, 32'h0080_0001);
    @(posedge clk); #1;
    checks++;
    if (frame_valid_o !== 1'b1 || frame_l_o !== 24'h7FFFFE || frame_r_o !== 24'h800001) begin
      errors++; $display("FAIL lat1_data: got valid=%b l=%h r=%h expected 1/7ffffe/800001", frame_valid_o, frame_l_o, frame_r_o);
    end
    @(posedge clk); #1;
    checks++;
    if (frame_valid_o !== 1'b0) begin errors++; $display("FAIL valid_width: got %b expected 0", frame_valid_o); end
`endif
  endtask

  initial begin
    test_reset();
    test_single_pair();
    test_overflow();
    test_underrun();
    test_irq_flush();
    test_async_reset();
    test_volume();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
